// File: rtl/pc_seq_unit.sv
// pc_seq_unit: parametrised program counter for the pipeline front end.
// Supports auto-increment, stall, and redirect. A one-deep buffer keeps a
// redirect that arrives during a stall until the stall is released.
// All state changes on the falling edge of clk. rst is asynchronous.
// Optional macro PC_REDIRECT_COUNT_EN adds a 32-bit saturating count of
// applied redirects. Without the macro, redirect_count is tied to zero.
module pc_seq_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = 4,
  parameter int               ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             redirect_pending,
  output logic             misalign,
  output logic [31:0]      redirect_count
);

  typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;
  typedef enum logic [1:0] {SEL_HOLD, SEL_STEP, SEL_TARGET, SEL_BUFFER} pc_sel_t;

  // A mask of zero (ALIGN_BITS = 0) turns the alignment check off.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

  state_t           state;
  state_t           state_next;
  pc_sel_t          pc_sel;
  logic             buf_load;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] target_clean;
  logic             target_bad;

  assign target_clean     = redirect_target & ~ALIGN_MASK;
  assign target_bad       = |(redirect_target & ALIGN_MASK);
  assign pc_out           = pc;
  assign pc_next_seq      = pc + STEP_W;
  assign redirect_pending = (state == HOLD_PEND);

  // State register: reset returns to RUN and drops any buffered redirect.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next-state logic: stall decides whether the FSM is in a hold state.
  // redirect_valid decides whether a target is waiting in the buffer.
  always_comb begin
    state_next = state;
    if (stall) begin
      if (redirect_valid || state == HOLD_PEND) state_next = HOLD_PEND;
      else                                      state_next = HOLD;
    end else begin
      state_next = RUN;
    end
  end

  // Datapath control: choose the PC source and when to load the buffer.
  // A new redirect takes priority over a buffered one.
  always_comb begin
    pc_sel   = SEL_HOLD;
    buf_load = 1'b0;
    if (stall) begin
      buf_load = redirect_valid;
    end else if (redirect_valid) begin
      pc_sel = SEL_TARGET;
    end else if (state == HOLD_PEND) begin
      pc_sel = SEL_BUFFER;
    end else begin
      pc_sel = SEL_STEP;
    end
  end

  // PC, redirect buffer and misalign pulse registers.
  // misalign flags any captured target whose low bits were not zero.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      pend_target <= '0;
      misalign    <= 1'b0;
    end else begin
      case (pc_sel)
        SEL_STEP:   pc <= pc + STEP_W;
        SEL_TARGET: pc <= target_clean;
        SEL_BUFFER: pc <= pend_target;
        default:    pc <= pc;
      endcase
      if (buf_load) pend_target <= target_clean;
      misalign <= redirect_valid && target_bad;
    end
  end

`ifdef PC_REDIRECT_COUNT_EN
  logic [31:0] count_q;
  logic        count_inc;

  assign count_inc      = (pc_sel == SEL_TARGET) || (pc_sel == SEL_BUFFER);
  assign redirect_count = count_q;

  // Applied-redirect counter. It stops at all-ones instead of wrapping.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)                              count_q <= '0;
    else if (count_inc && count_q != '1)  count_q <= count_q + 32'd1;
  end
`else
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed bench for pc_seq_unit.
// The main instance is 32 bits wide with reset vector 0x100.
// A second, 8-bit instance checks that the PC wraps to zero.
module tb_pc_seq_unit;

`ifdef PC_REDIRECT_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_out;
  logic [31:0] pc_next_seq;
  logic        redirect_pending;
  logic        misalign;
  logic [31:0] redirect_count;

  logic [7:0]  w8_pc;
  logic [7:0]  w8_next;
  logic        w8_pending;
  logic        w8_misalign;
  logic [31:0] w8_count;

  int vectors  = 0;
  int failures = 0;

  pc_seq_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h100), .STEP(4), .ALIGN_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc_out(pc_out), .pc_next_seq(pc_next_seq),
    .redirect_pending(redirect_pending), .misalign(misalign),
    .redirect_count(redirect_count)
  );

  pc_seq_unit #(
    .WIDTH(8), .RESET_VECTOR(8'hF0), .STEP(4), .ALIGN_BITS(2)
  ) dut_w8 (
    .clk(clk), .rst(rst), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_target(8'h00),
    .pc_out(w8_pc), .pc_next_seq(w8_next),
    .redirect_pending(w8_pending), .misalign(w8_misalign),
    .redirect_count(w8_count)
  );

  // Free-running clock. The DUT updates on each falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the falling edge.
  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] tgt);
    stall           = s;
    redirect_valid  = rv;
    redirect_target = tgt;
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] e_pc, input logic e_pend,
                             input logic e_mis, input logic [31:0] e_cnt);
    cmp({tag, ".pc"},   pc_out,                   e_pc);
    cmp({tag, ".seq"},  pc_next_seq,              e_pc + 32'd4);
    cmp({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, e_pend});
    cmp({tag, ".mis"},  {31'd0, misalign},        {31'd0, e_mis});
    cmp({tag, ".cnt"},  redirect_count,           e_cnt);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    @(negedge clk);
    #1;
    checkOutput("reset", 32'h100, 1'b0, 1'b0, 32'd0);
    cmp("w8.reset", {24'd0, w8_pc}, 32'hF0);
    rst = 1'b0;

    // Sequential increment from the reset vector.
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("inc1", 32'h104, 1'b0, 1'b0, exp_cnt(0));
    cmp("w8.inc1", {24'd0, w8_pc}, 32'hF4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("inc2", 32'h108, 1'b0, 1'b0, exp_cnt(0));
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("inc3", 32'h10C, 1'b0, 1'b0, exp_cnt(0));
    cmp("w8.pre_wrap", {24'd0, w8_pc}, 32'hFC);
    cmp("w8.seq_wrap", {24'd0, w8_next}, 32'h00);

    // Immediate redirects: first move to 0x10, then redirect to 0x200.
    applyStimulus(1'b0, 1'b1, 32'h10);
    checkOutput("redir_0x10", 32'h10, 1'b0, 1'b0, exp_cnt(1));
    cmp("w8.wrap", {24'd0, w8_pc}, 32'h00);
    applyStimulus(1'b0, 1'b1, 32'h200);
    checkOutput("redir_0x200", 32'h200, 1'b0, 1'b0, exp_cnt(2));
    applyStimulus(1'b0, 1'b1, 32'h20);
    checkOutput("redir_0x20", 32'h20, 1'b0, 1'b0, exp_cnt(3));

    // A redirect during a stall is buffered and applied on release.
    applyStimulus(1'b1, 1'b1, 32'h300);
    checkOutput("stall_buf", 32'h20, 1'b1, 1'b0, exp_cnt(3));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stall_hold", 32'h20, 1'b1, 1'b0, exp_cnt(3));
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stall_release", 32'h300, 1'b0, 1'b0, exp_cnt(4));
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("after_release", 32'h304, 1'b0, 1'b0, exp_cnt(4));

    // Buffer overwrite, then a new redirect on release beats the buffer.
    applyStimulus(1'b1, 1'b1, 32'h300);
    checkOutput("ovr_buf", 32'h304, 1'b1, 1'b0, exp_cnt(4));
    applyStimulus(1'b1, 1'b1, 32'h400);
    checkOutput("ovr_buf2", 32'h304, 1'b1, 1'b0, exp_cnt(4));
    applyStimulus(1'b0, 1'b1, 32'h500);
    checkOutput("ovr_new_wins", 32'h500, 1'b0, 1'b0, exp_cnt(5));

    // HOLD without a buffered redirect, released plain and with a redirect.
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("hold", 32'h500, 1'b0, 1'b0, exp_cnt(5));
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("hold_inc", 32'h504, 1'b0, 1'b0, exp_cnt(5));
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("hold2", 32'h504, 1'b0, 1'b0, exp_cnt(5));
    applyStimulus(1'b0, 1'b1, 32'h600);
    checkOutput("hold_redir", 32'h600, 1'b0, 1'b0, exp_cnt(6));

    // Misaligned targets: low bits are cleared and misalign pulses once.
    applyStimulus(1'b0, 1'b1, 32'h203);
    checkOutput("misalign", 32'h200, 1'b0, 1'b1, exp_cnt(7));
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("misalign_clr", 32'h204, 1'b0, 1'b0, exp_cnt(7));
    applyStimulus(1'b1, 1'b1, 32'h3FF);
    checkOutput("misalign_buf", 32'h204, 1'b1, 1'b1, exp_cnt(7));
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("misalign_buf_apply", 32'h3FC, 1'b0, 1'b0, exp_cnt(8));

    // Asynchronous reset between edges while in HOLD_PEND.
    applyStimulus(1'b1, 1'b1, 32'h700);
    checkOutput("pre_reset_pend", 32'h3FC, 1'b1, 1'b0, exp_cnt(8));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 32'h100, 1'b0, 1'b0, 32'd0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("post_reset", 32'h104, 1'b0, 1'b0, exp_cnt(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
